spi_master_param: RTL and testbench
===================================

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 SHALL have parameter WIDTH, default 15: bits per frame; legal range 2..64.
REQ-002 SHALL have parameter NSS, default 4: number of slave-select lines; legal range 1..16.
REQ-003 SHALL have parameter DIVW, default 16: width of the half-period divisor input.
REQ-004 SHALL have parameter SELW, default 2: width of SEL; 2**SELW >= NSS.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 R  in  1  reset, synchronous, active-high.
REQ-007 st  in  1  start request, sampled each clk.
REQ-008 DIV  in  DIVW  SCLK half-period in clk cycles.
REQ-009 CPOL  in  1  SCLK idle level.
REQ-010 CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-011 LEFT  in  1  1 = MSB first, 0 = LSB first.
REQ-012 SEL  in  SELW  index of the slave select to drive.
REQ-013 TX_MD  in  WIDTH  transmit word.
REQ-014 RX_SD  out  WIDTH  last received word.
REQ-015 MISO  in  1  serial data from slave.
REQ-016 MOSI  out  1  serial data to slave.
REQ-017 SCLK  out  1  serial clock.
REQ-018 SS_N  out  NSS  active-low slave selects.
REQ-019 busy  out  1  transfer in progress.
REQ-020 done  out  1  one-cycle pulse at frame end.

Function
REQ-021 SHALL implement FSM states IDLE, LEAD, XFER, TRAIL.
REQ-022 In IDLE with st=1 at cycle t0: latch DIV, CPOL, CPHA, LEFT, SEL, TX_MD; enter LEAD at t0+1.
REQ-023 SHALL treat latched DIV=0 as 1; the effective half-period is h = max(DIV,1).
REQ-024 LEAD: busy=1, SS_N[SEL]=0, SCLK=CPOL, MOSI=first bit (TX_MD[WIDTH-1] if LEFT, else TX_MD[0]); lasts h cycles.
REQ-025 XFER: SCLK toggles every h cycles, giving 2*WIDTH edges; edge k (1..2*WIDTH) occurs at cycle t0+1+k*h.
REQ-026 CPHA=0: sample MISO on odd edges; shift next bit onto MOSI on even edges, except the last edge.
REQ-027 CPHA=1: shift next bit onto MOSI on odd edges, except the first edge, where MOSI keeps the first bit; sample MISO on even edges.
REQ-028 Received bits SHALL be assembled in the same order as transmitted per latched LEFT, so loopback yields RX_SD == TX_MD.
REQ-029 TRAIL: SCLK=CPOL, SS_N held, lasts h cycles.
REQ-030 At cycle t0+1+(2*WIDTH+1)*h: SS_N all 1, busy=0, done=1 for one cycle, RX_SD updated; return to IDLE.
REQ-031 RX_SD SHALL hold its value between done pulses.
REQ-032 st while busy=1 SHALL be ignored; st in the cycle done=1 SHALL be accepted (back-to-back frames).
REQ-033 Input changes after latch SHALL NOT affect the frame in progress.
REQ-034 SEL >= NSS: the frame runs with full timing and done, but no SS_N line asserts.
REQ-035 In IDLE: SCLK follows the live CPOL, MOSI=0.

Reset
REQ-036 R=1 SHALL force IDLE, busy=0, done=0, SS_N all 1, MOSI=0, SCLK=CPOL, RX_SD=0, and clear the divider and bit counters.
REQ-037 R asserted mid-frame SHALL abort immediately with no done pulse; RX_SD stays 0.
REQ-038 R SHALL take priority over st in the same cycle.

Verification
REQ-039 WIDTH=15, DIV=2, CPOL=0, CPHA=0, LEFT=1, SEL=1, TX_MD=15'b010110000110110, MISO tied to MOSI -> SS_N=4'b1101 during frame; done at t0+63; RX_SD=15'b010110000110110.
REQ-040 CPOL=1, CPHA=1, LEFT=0, DIV=3, slave model returning 15'b110101100110110 -> RX_SD=15'b110101100110110; SCLK idles 1; 30 edges spaced 3 cycles apart.
REQ-041 DIV=0, loopback, TX_MD=15'h7FFF -> behaves as DIV=1; done at t0+32; RX_SD=15'h7FFF.
REQ-042 st pulsed at edge 5 of an active frame -> ignored, single done; st held high through done -> second frame starts at the done cycle +1.
REQ-043 R=1 at edge 10 -> next cycle SS_N=4'b1111, busy=0, no done; a new st after R falls gives a correct full frame.
REQ-044 SEL=3 with NSS=3 -> SS_N stays 3'b111; done still at the expected cycle.

Source files
------------

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one frame of WIDTH bits per start request,
// programmable SCLK half-period, CPOL/CPHA modes, MSB/LSB-first order and
// NSS one-hot active-low slave selects.
//
// Handshake: st is a level sampled every clk. It is accepted only while the
// FSM is idle, which includes the cycle in which done pulses, so a held st
// runs frames back to back. busy is high from the first LEAD cycle through
// the last TRAIL cycle. done is high for exactly one cycle, and RX_SD takes
// the received word in that same cycle. RX_SD then holds until the next done.
module spi_master_param #(
    parameter int WIDTH = 15,
    parameter int NSS   = 4,
    parameter int DIVW  = 16,
    parameter int SELW  = 2
) (
    input  logic             clk,
    input  logic             R,
    input  logic             st,
    input  logic [DIVW-1:0]  DIV,
    input  logic             CPOL,
    input  logic             CPHA,
    input  logic             LEFT,
    input  logic [SELW-1:0]  SEL,
    input  logic [WIDTH-1:0] TX_MD,
    output logic [WIDTH-1:0] RX_SD,
    input  logic             MISO,
    output logic             MOSI,
    output logic             SCLK,
    output logic [NSS-1:0]   SS_N,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int ECW = $clog2(2 * WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t           state_q, state_d;
    logic [DIVW-1:0]  div_q, div_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic             left_q, left_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_sd_q, rx_sd_d;
    logic [DIVW-1:0]  cnt_q, cnt_d;
    logic [ECW-1:0]   edge_q, edge_d;
    logic             sclk_q, sclk_d;
    logic             done_q, done_d;

    logic [DIVW-1:0]  half_last;
    logic             half_end;
    logic             edge_odd;
    logic             first_edge;
    logic             last_edge;
    logic             do_sample;
    logic             do_shift;

    // Next-state logic: half-period timer, edge counter, shift/sample control
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        left_d    = left_q;
        sel_d     = sel_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_sd_d   = rx_sd_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        sclk_d    = sclk_q;
        done_d    = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;

        // A latched divisor of zero behaves exactly like one.
        half_last  = (div_q == '0) ? '0 : div_q - DIVW'(1);
        half_end   = (cnt_q == half_last);
        // edge_q counts edges already made, so the edge about to happen is edge_q+1.
        edge_odd   = ~edge_q[0];
        first_edge = (edge_q == '0);
        last_edge  = (edge_q == ECW'(2 * WIDTH - 1));

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                edge_d = '0;
                if (st) begin
                    div_d   = DIV;
                    cpol_d  = CPOL;
                    cpha_d  = CPHA;
                    left_d  = LEFT;
                    sel_d   = SEL;
                    tx_d    = TX_MD;
                    sclk_d  = CPOL;
                    state_d = LEAD;
                end
            end
            LEAD, XFER: begin
                if (half_end) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + ECW'(1);
                    if (cpha_q) begin
                        do_sample = ~edge_odd;
                        do_shift  = edge_odd & ~first_edge;
                    end else begin
                        do_sample = edge_odd;
                        do_shift  = ~edge_odd & ~last_edge;
                    end
                    state_d = last_edge ? TRAIL : XFER;
                end else begin
                    cnt_d = cnt_q + DIVW'(1);
                end
            end
            TRAIL: begin
                if (half_end) begin
                    cnt_d   = '0;
                    edge_d  = '0;
                    done_d  = 1'b1;
                    rx_sd_d = rx_sh_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DIVW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Receive order mirrors transmit order so a loopback returns TX_MD.
        if (do_shift) begin
            tx_d = left_q ? (tx_q << 1) : (tx_q >> 1);
        end
        if (do_sample) begin
            rx_sh_d = left_q ? {rx_sh_q[WIDTH-2:0], MISO} : {MISO, rx_sh_q[WIDTH-1:1]};
        end
    end

    // State registers with synchronous reset taking priority over st
    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= IDLE;
            div_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            left_q  <= 1'b0;
            sel_q   <= '0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_sd_q <= '0;
            cnt_q   <= '0;
            edge_q  <= '0;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            left_q  <= left_d;
            sel_q   <= sel_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            rx_sd_q <= rx_sd_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
        end
    end

    // Output decode: idle SCLK tracks live CPOL; an out-of-range SEL asserts no line
    always_comb begin
        busy      = (state_q != IDLE);
        done      = done_q;
        RX_SD     = rx_sd_q;
        dbg_state = state_q;
        SCLK      = busy ? sclk_q : CPOL;
        MOSI      = busy ? (left_q ? tx_q[WIDTH-1] : tx_q[0]) : 1'b0;
        for (int i = 0; i < NSS; i++) begin
            SS_N[i] = ~(busy && (int'(sel_q) == i));
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: table of frame vectors checked through a
// scoreboard, plus hand sequences for ignored/back-to-back starts, mid-frame
// reset and an out-of-range slave select on a 3-select instance.
module tb_spi_master_param;

    localparam int W = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          r, st, st_b;
    logic [15:0]   div;
    logic          cpol, cpha, left;
    logic [1:0]    sel, sel_b;
    logic [W-1:0]  tx;
    logic [W-1:0]  rx_sd, rx_sd_b;
    logic          miso, mosi, sclk, busy, done;
    logic          miso_b, mosi_b, sclk_b, busy_b, done_b;
    logic [3:0]    ss_n;
    logic [2:0]    ss_n_b;
    logic [1:0]    dbg_state, dbg_state_b;

    spi_master_param #(.WIDTH(W), .NSS(4), .DIVW(16), .SELW(2)) dut (
        .clk(clk), .R(r), .st(st), .DIV(div), .CPOL(cpol), .CPHA(cpha),
        .LEFT(left), .SEL(sel), .TX_MD(tx), .RX_SD(rx_sd), .MISO(miso),
        .MOSI(mosi), .SCLK(sclk), .SS_N(ss_n), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    spi_master_param #(.WIDTH(W), .NSS(3), .DIVW(16), .SELW(2)) dut_b (
        .clk(clk), .R(r), .st(st_b), .DIV(div), .CPOL(cpol), .CPHA(cpha),
        .LEFT(left), .SEL(sel_b), .TX_MD(tx), .RX_SD(rx_sd_b), .MISO(miso_b),
        .MOSI(mosi_b), .SCLK(sclk_b), .SS_N(ss_n_b), .busy(busy_b), .done(done_b),
        .dbg_state(dbg_state_b)
    );

    assign miso_b = mosi_b;

    // ---------------- counters and check helper ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    logic          loop_mode = 1'b1;
    logic [W-1:0]  slave_word = '0;
    logic          cur_cpha = 1'b0, cur_left = 1'b1;
    logic [3:0]    cur_ss_exp = 4'hF;
    int            edge_n = 0;
    int            s_idx;
    logic          slave_bit;

    // Slave presents bit idx; CPHA=0 advances after each trailing edge,
    // CPHA=1 presents its first bit at the leading edge and advances on later leading edges.
    always_comb begin
        if (cur_cpha) s_idx = (edge_n == 0) ? 0 : (edge_n - 1) / 2;
        else          s_idx = edge_n / 2;
        if (s_idx > W - 1) s_idx = W - 1;
        slave_bit = slave_word[cur_left ? (W - 1 - s_idx) : s_idx];
    end
    assign miso = loop_mode ? mosi : slave_bit;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           exp_h_q[$];

    logic         prev_sclk = 1'b0;
    int           last_edge_cyc = 0;
    int           spacing_bad = 0;
    logic [W-1:0] e_rx;
    int           e_cyc, e_h;

    always @(negedge clk) begin
        if (busy && sclk !== prev_sclk) begin
            edge_n++;
            if (edge_n == 1) chk("ss_n_in_frame", ss_n, cur_ss_exp);
            else if (exp_h_q.size() > 0 && (cyc - last_edge_cyc) != exp_h_q[0]) spacing_bad++;
            last_edge_cyc = cyc;
        end
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
            end else begin
                e_rx  = exp_q.pop_front();
                e_cyc = exp_cyc_q.pop_front();
                e_h   = exp_h_q.pop_front();
                chk("rx_sd", rx_sd, e_rx);
                chk("done_cycle", cyc, e_cyc);
                chk("edge_count", edge_n, 2 * W);
                chk("last_edge_cycle", last_edge_cyc, e_cyc - e_h);
                chk("edge_spacing_errors", spacing_bad, 0);
            end
        end
        if (!busy) begin
            edge_n      = 0;
            spacing_bad = 0;
        end
        prev_sclk = sclk;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0]  div;
        logic         cpol, cpha, left;
        logic [1:0]   sel;
        logic [W-1:0] tx;
        logic         loop;
        logic [W-1:0] sword;
        logic [W-1:0] exp_rx;
        logic [3:0]   exp_ss;
    } vec_t;

    vec_t vecs[6];

    // ---------------- driver tasks ----------------
    task automatic apply(input vec_t v);
        div        = v.div;
        cpol       = v.cpol;
        cpha       = v.cpha;
        left       = v.left;
        sel        = v.sel;
        tx         = v.tx;
        loop_mode  = v.loop;
        slave_word = v.sword;
        cur_cpha   = v.cpha;
        cur_left   = v.left;
        cur_ss_exp = v.exp_ss;
    endtask

    // Raise st for one cycle and queue the expected result.
    task automatic start(input vec_t v, output int t0);
        int h;
        h  = (v.div == 0) ? 1 : int'(v.div);
        st = 1'b1;
        t0 = cyc;
        exp_q.push_back(v.exp_rx);
        exp_cyc_q.push_back(t0 + 1 + (2 * W + 1) * h);
        exp_h_q.push_back(h);
    endtask

    task automatic scramble();
        div  = 16'($urandom_range(0, 7));
        cpol = 1'($urandom_range(0, 1));
        cpha = 1'($urandom_range(0, 1));
        left = 1'($urandom_range(0, 1));
        sel  = 2'($urandom_range(0, 3));
        tx   = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d frames pending, expected 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
            exp_h_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t0;
        @(negedge clk);
        apply(v);
        @(negedge clk);
        chk("idle_sclk", sclk, v.cpol);
        chk("idle_mosi", mosi, 0);
        start(v, t0);
        @(negedge clk);
        st = 1'b0;
        scramble();
        drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t0, n_before, n, ss_bad, t0b, got_b;
        vecs[0] = '{16'd2, 1'b0, 1'b0, 1'b1, 2'd1, 15'b010110000110110, 1'b1, 15'h0000,
                    15'b010110000110110, 4'b1101};
        vecs[1] = '{16'd3, 1'b1, 1'b1, 1'b0, 2'd0, 15'h1234, 1'b0, 15'b110101100110110,
                    15'b110101100110110, 4'b1110};
        vecs[2] = '{16'd0, 1'b0, 1'b1, 1'b1, 2'd2, 15'h7FFF, 1'b1, 15'h0000, 15'h7FFF, 4'b1011};
        vecs[3] = '{16'd1, 1'b1, 1'b0, 1'b1, 2'd3, 15'h4001, 1'b0, 15'h2AAA, 15'h2AAA, 4'b0111};
        vecs[4] = '{16'd4, 1'b0, 1'b1, 1'b0, 2'd1, 15'h5A5A, 1'b1, 15'h0000, 15'h5A5A, 4'b1101};
        vecs[5] = '{16'd1, 1'b1, 1'b0, 1'b0, 2'd2, 15'h0001, 1'b0, 15'h6B3C, 15'h6B3C, 4'b1011};

        r = 1'b1; st = 1'b0; st_b = 1'b0; sel_b = 2'd3;
        div = 16'd2; cpol = 1'b1; cpha = 1'b0; left = 1'b1; sel = 2'd0; tx = '0;

        // Reset state, with st asserted alongside reset to show reset wins.
        repeat (3) @(negedge clk);
        st = 1'b1;
        @(negedge clk);
        chk("reset_ss_n", ss_n, 4'hF);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_mosi", mosi, 0);
        chk("reset_sclk", sclk, 1);
        chk("reset_rx_sd", rx_sd, 0);
        chk("reset_state", dbg_state, 0);
        st = 1'b0;
        r  = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        chk("rx_sd_holds", rx_sd, vecs[5].exp_rx);

        // st pulsed at edge 5 of a running frame is ignored.
        n_before = n_done;
        @(negedge clk);
        apply(vecs[0]);
        @(negedge clk);
        start(vecs[0], t0);
        @(negedge clk);
        st = 1'b0;
        while (cyc < t0 + 1 + 5 * 2) @(negedge clk);
        st = 1'b1;
        tx = 15'h0F0F;
        @(negedge clk);
        st = 1'b0;
        tx = vecs[0].tx;
        drain();
        repeat (80) @(negedge clk);
        chk("single_done_count", n_done - n_before, 1);

        // st held high through done: second frame starts the cycle after done.
        n_before = n_done;
        @(negedge clk);
        apply(vecs[4]);
        @(negedge clk);
        start(vecs[4], t0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 2000);
        chk("b2b_first_done_seen", done, 1);
        start(vecs[4], t0);
        @(negedge clk);
        st = 1'b0;
        drain();
        chk("b2b_done_count", n_done - n_before, 2);

        // Reset at edge 10 aborts the frame with no done.
        n_before = n_done;
        @(negedge clk);
        apply(vecs[1]);
        @(negedge clk);
        start(vecs[1], t0);
        @(negedge clk);
        st = 1'b0;
        while (cyc < t0 + 1 + 10 * 3) @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        chk("abort_ss_n", ss_n, 4'hF);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rx_sd", rx_sd, 0);
        chk("abort_state", dbg_state, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        exp_h_q.delete();
        r = 1'b0;
        repeat (120) @(negedge clk);
        chk("abort_no_done", n_done - n_before, 0);
        run_vec(vecs[1]);

        // SEL out of range on the 3-select instance: no select asserts, timing intact.
        @(negedge clk);
        div = 16'd2; cpol = 1'b0; cpha = 1'b0; left = 1'b1; tx = 15'h3C5A;
        @(negedge clk);
        st_b = 1'b1;
        t0b  = cyc;
        @(negedge clk);
        st_b   = 1'b0;
        ss_bad = 0;
        got_b  = -1;
        n      = 0;
        while (got_b < 0 && n < 500) begin
            if (ss_n_b !== 3'b111) ss_bad++;
            if (done_b) got_b = cyc;
            @(negedge clk);
            n++;
        end
        chk("selw_ss_n_low_cycles", ss_bad, 0);
        chk("selw_done_cycle", got_b, t0b + 63);
        chk("selw_rx_sd", rx_sd_b, 15'h3C5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish by cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
